// File: rtl/c_b_pkg.sv
// c_b_pkg: shared definitions for the c-to-b link transmit side.
//   C_B_W        forward word width (135)
//   *_BIT/*_LSB  field offsets inside the forward word
//   c_b_word_t   packed view of the forward word
//   credit_t     credit counter / depth type
//   c_b_state_t  link FSM state
package c_b_pkg;

    localparam int C_B_W    = 135;
    localparam int DATA_W   = 128;
    localparam int SEQ_FW   = 4;
    localparam int NB_W     = 2;
    localparam int CREDIT_W = 6;

    localparam int LAST_BIT = 134;
    localparam int NB_LSB   = 132;
    localparam int SEQ_LSB  = 128;
    localparam int DATA_LSB = 0;

    typedef struct packed {
        logic              last;
        logic [NB_W-1:0]   nbeats;   // beats in word minus one
        logic [SEQ_FW-1:0] seq;
        logic [DATA_W-1:0] data;
    } c_b_word_t;

    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } c_b_state_t;

endpackage

// File: rtl/c_b_credit_ctr.sv
// c_b_credit_ctr: credit counter for the c-to-b link.
//   clk, rst_n  clock / async active-low reset
//   load        latch load_val as both the credit count and the ceiling
//   load_val    advertised credit depth from b
//   ret         one credit returned this cycle
//   send        one credit consumed this cycle
//   credits     current credit count
//   err_ovf     sticky: a credit came back while already at the ceiling
module c_b_credit_ctr
    import c_b_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  credit_t load_val,
    input  logic    ret,
    input  logic    send,
    output credit_t credits,
    output logic    err_ovf
);

    credit_t cmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
            cmax    <= '0;
            err_ovf <= 1'b0;
        end else if (load) begin
            credits <= load_val;
            cmax    <= load_val;
        end else begin
            case ({ret, send})
                2'b10: begin
                    // A return at the ceiling means b handed back more
                    // than it granted; keep the count sane and flag it.
                    if (credits == cmax) err_ovf <= 1'b1;
                    else                 credits <= credits + credit_t'(1);
                end
                2'b01:   credits <= credits - credit_t'(1);
                default: ;  // idle, or return and send cancel out
            endcase
        end
    end

endmodule

// File: rtl/c_b_tx.sv
// c_b_tx: transmit end of the c-to-b link.
// Packs IN_W-bit upstream beats into BEATS-lane words, holds one finished
// word in an out register and sends it to b when a credit is available.
//   clk, rst_n  clock / async active-low reset
//   in_data/in_valid/in_last/in_ready  upstream beat handshake
//   c_b_0       forward word {last, nbeats-1, seq, data}
//   c_b_1       forward word valid (send strobe)
//   b_c_0       credit return, one per high cycle
//   b_c_1       credit depth advertised by b; nonzero starts the link
//   credits     current credit count
//   err_ovf     sticky credit-overflow error
module c_b_tx
    import c_b_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int BEATS = 4,
    parameter int SEQ_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [C_B_W-1:0] c_b_0,
    output logic             c_b_1,
    input  logic             b_c_0,
    input  logic [5:0]       b_c_1,
    output logic [5:0]       credits,
    output logic             err_ovf
);

    if (IN_W*BEATS + SEQ_W + 3 != C_B_W) begin : g_bad_width
        $error("c_b_tx: IN_W*BEATS + SEQ_W + 3 must equal 135");
    end
    if (IN_W*BEATS != DATA_W || SEQ_W != SEQ_FW) begin : g_bad_fields
        $error("c_b_tx: field widths disagree with c_b_pkg");
    end

    c_b_state_t                  state;
    logic [NB_W-1:0]             beat_idx;
    logic [BEATS-1:0][IN_W-1:0]  pack_q;
    logic [BEATS-1:0][IN_W-1:0]  word_data;
    logic                        out_valid;
    logic                        out_last;
    logic [NB_W-1:0]             out_nb;
    logic [BEATS-1:0][IN_W-1:0]  out_data;
    logic [SEQ_W-1:0]            seq;
    c_b_word_t                   out_word;

    logic run, send, completes, accept, load;

    assign run       = (state == RUN);
    assign load      = (state == INIT) && (b_c_1 != '0);
    assign send      = out_valid && (credits != '0) && run;
    assign completes = in_last || (beat_idx == NB_W'(BEATS-1));
    // A completing beat needs the out register free by the same edge.
    assign in_ready  = run && !(completes && out_valid && !send);
    assign accept    = in_valid && in_ready;

    assign c_b_1 = send;

    // Seq is stamped from the live counter, so a word stalled on credits
    // always shows the number it will actually be sent with.
    always_comb begin
        out_word        = '0;
        out_word.last   = out_last;
        out_word.nbeats = out_nb;
        out_word.seq    = seq;
        out_word.data   = out_data;
    end
    assign c_b_0 = out_valid ? out_word : '0;

    // Lanes past beat_idx are already zero because pack_q is cleared on
    // every completion, so a short word needs no extra masking.
    always_comb begin
        word_data           = pack_q;
        word_data[beat_idx] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else if (load) state <= RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx  <= '0;
            pack_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_nb    <= '0;
            out_data  <= '0;
            seq       <= '0;
        end else begin
            if (send) seq <= seq + SEQ_W'(1);

            if (accept && completes) begin
                out_valid <= 1'b1;
                out_last  <= in_last;
                out_nb    <= beat_idx;
                out_data  <= word_data;
                pack_q    <= '0;
                beat_idx  <= '0;
            end else begin
                if (send) out_valid <= 1'b0;
                if (accept) begin
                    pack_q[beat_idx] <= in_data;
                    beat_idx         <= beat_idx + NB_W'(1);
                end
            end
        end
    end

    c_b_credit_ctr u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (b_c_1),
        .ret      (b_c_0 && run),
        .send     (send),
        .credits  (credits),
        .err_ovf  (err_ovf)
    );

endmodule

// File: tb/tb_c_b_tx.sv
// tb_c_b_tx: directed bench for c_b_tx with hand-computed expected words.
module tb_c_b_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid, in_last, in_ready;
    logic [134:0] c_b_0;
    logic         c_b_1;
    logic         b_c_0;
    logic [5:0]   b_c_1;
    logic [5:0]   credits;
    logic         err_ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    c_b_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .c_b_0    (c_b_0),
        .c_b_1    (c_b_1),
        .b_c_0    (b_c_0),
        .b_c_1    (b_c_1),
        .credits  (credits),
        .err_ovf  (err_ovf)
    );

    task automatic chk(input string tag, input logic [134:0] got, input logic [134:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [134:0] mk(input logic last, input logic [1:0] nb,
                                        input logic [3:0] seq, input logic [127:0] data);
        return {last, nb, seq, data};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic [31:0] d, input logic l);
        int n = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("beat_accept_timeout", 135'(in_ready), 135'(1));
        @(posedge clk); #2;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic credit_pulse;
        b_c_0 = 1'b1; tick; b_c_0 = 1'b0;
    endtask

    // Check that the expected word is on the link this cycle, then let it go.
    task automatic expect_send(input string tag, input logic [134:0] w);
        chk({tag, "_vld"}, 135'(c_b_1), 135'(1));
        chk({tag, "_word"}, c_b_0, w);
        tick;
    endtask

    logic [134:0] w;
    logic [3:0]   eseq;

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        b_c_0 = 1'b0; b_c_1 = '0;
        #13;
        chk("rst_in_ready", 135'(in_ready), 135'(0));
        chk("rst_c_b_1",    135'(c_b_1),    135'(0));
        chk("rst_c_b_0",    c_b_0,          135'(0));
        chk("rst_credits",  135'(credits),  135'(0));
        chk("rst_err_ovf",  135'(err_ovf),  135'(0));
        @(negedge clk); rst_n = 1'b1;

        // INIT: stays closed while b advertises nothing; returns ignored
        b_c_0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("init_in_ready", 135'(in_ready), 135'(0));
            chk("init_credits",  135'(credits),  135'(0));
        end
        b_c_0 = 1'b0;
        b_c_1 = 6'd3;
        tick;
        b_c_1 = 6'd0;
        chk("run_credits",  135'(credits),  135'(3));
        chk("run_in_ready", 135'(in_ready), 135'(1));

        // Two full words
        for (int i = 1; i <= 4; i++) beat(32'(i), 1'b0);
        expect_send("word0", mk(1'b0, 2'd3, 4'd0,
                    {32'h4, 32'h3, 32'h2, 32'h1}));
        chk("word0_credits", 135'(credits), 135'(2));
        for (int i = 5; i <= 8; i++) beat(32'(i), 1'b0);
        expect_send("word1", mk(1'b0, 2'd3, 4'd1,
                    {32'h8, 32'h7, 32'h6, 32'h5}));
        chk("word1_credits", 135'(credits), 135'(1));

        // Partial word closed by in_last
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b1);
        expect_send("partial", mk(1'b1, 2'd1, 4'd2,
                    {64'h0, 32'hB, 32'hA}));
        chk("partial_credits", 135'(credits), 135'(0));

        // Credit stall: word held stable with no credits
        w = mk(1'b0, 2'd3, 4'd3, {32'hF, 32'hE, 32'hD, 32'hC});
        beat(32'hC, 1'b0); beat(32'hD, 1'b0); beat(32'hE, 1'b0); beat(32'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_vld",  135'(c_b_1), 135'(0));
            chk("stall_word", c_b_0, w);
            tick;
        end
        credit_pulse;
        expect_send("unstall", w);
        chk("unstall_credits", 135'(credits), 135'(0));

        // Send coinciding with a credit return
        credit_pulse;
        chk("one_credit", 135'(credits), 135'(1));
        for (int i = 0; i < 4; i++) beat(32'h11 + 32'(i), 1'b0);
        b_c_0 = 1'b1;
        expect_send("simul", mk(1'b0, 2'd3, 4'd4, {32'h14, 32'h13, 32'h12, 32'h11}));
        b_c_0 = 1'b0;
        chk("simul_credits", 135'(credits), 135'(1));

        // Overflow at the ceiling
        credit_pulse; credit_pulse;
        chk("full_credits", 135'(credits), 135'(3));
        chk("full_no_ovf",  135'(err_ovf), 135'(0));
        credit_pulse;
        chk("ovf_credits", 135'(credits), 135'(3));
        chk("ovf_flag",    135'(err_ovf), 135'(1));
        tick; tick; tick;
        chk("ovf_sticky", 135'(err_ovf), 135'(1));

        // 17 single-beat words: seq walks 5..15 and wraps through 0
        eseq = 4'd5;
        for (int i = 0; i < 17; i++) begin
            beat(32'h100 + 32'(i), 1'b1);
            b_c_0 = 1'b1;   // refund each credit as it is used
            expect_send("wrap", mk(1'b1, 2'd0, eseq, {96'h0, 32'h100 + 32'(i)}));
            b_c_0 = 1'b0;
            eseq = eseq + 4'd1;
        end
        chk("wrap_credits", 135'(credits), 135'(3));

        // Reset in the middle of a packet
        beat(32'h55, 1'b0);
        beat(32'h66, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 135'(in_ready), 135'(0));
        chk("mid_rst_c_b_1",    135'(c_b_1),    135'(0));
        chk("mid_rst_c_b_0",    c_b_0,          135'(0));
        chk("mid_rst_credits",  135'(credits),  135'(0));
        chk("mid_rst_err_ovf",  135'(err_ovf),  135'(0));
        @(negedge clk); rst_n = 1'b1;
        b_c_1 = 6'd2;
        tick;
        b_c_1 = 6'd0;
        chk("reinit_credits", 135'(credits), 135'(2));
        for (int i = 0; i < 4; i++) beat(32'h21 + 32'(i), 1'b0);
        expect_send("reinit", mk(1'b0, 2'd3, 4'd0, {32'h24, 32'h23, 32'h22, 32'h21}));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
